// File: rtl/cond_logic_if.sv
// Decoder-to-condition-stage bus: decoded write requests in, committed writes and flag state out.
// The master modport is the decoder side; the slave modport is the condition stage.
interface cond_logic_if;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       Stall;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;

    modport master (
        output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags
    );
endinterface

// File: rtl/cond_logic.sv
// Conditional-execution stage: holds NZCV, evaluates the ARM condition field against it,
// and gates the decoder's write requests into committed writes.
module cond_logic #(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input logic          clk,
    input logic          reset,
    cond_logic_if.slave  bus
);

    logic [3:0] flags;
    logic       condEx;
    logic       go;

    function automatic logic condPass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        logic r;
        {n, z, c, v} = f;
        r = 1'b0;
        case (cond)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = c;
            4'b0011: r = ~c;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = c & ~z;
            4'b1001: r = ~c | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Evaluated against the registered flags only, so an instruction never sees its own update.
    always_comb begin
        condEx = condPass(bus.Cond, flags);
        go     = condEx & ~bus.Stall & ~reset;
    end

    always_comb begin
        bus.CondEx   = condEx;
        bus.Flags    = flags;
        bus.PCSrc    = bus.PCS  & go;
        bus.RegWrite = bus.RegW & go & ~bus.NoWrite;
        bus.MemWrite = bus.MemW & go;
    end

    // N,Z and C,V are enabled independently so logical S-ops keep the carry and overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= FLAG_RESET;
        end else if (!bus.Stall) begin
            if (bus.FlagW[1] && condEx) flags[3:2] <= bus.ALUFlags[3:2];
            if (bus.FlagW[0] && condEx) flags[1:0] <= bus.ALUFlags[1:0];
        end
    end

endmodule

// File: tb/tb_cond_logic.sv
// Directed and random checks of cond_logic against a behavioural NZCV/condition model.
module tb_cond_logic;

    localparam logic [3:0] FR = 4'b0000;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    logic [3:0] mFlags;

    cond_logic_if bus ();

    cond_logic #(.FLAG_RESET(FR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ARM grouping: pairs of codes share a predicate, the low bit inverts it, 1111 is never.
    function automatic logic refCond(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v, p;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (code >> 1)
            3'd0: p = z;
            3'd1: p = c;
            3'd2: p = n;
            3'd3: p = v;
            3'd4: p = c && !z;
            3'd5: p = (n == v);
            3'd6: p = !z && (n == v);
            default: p = 1'b1;
        endcase
        if (code == 4'hF) return 1'b0;
        return p ^ code[0];
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one instruction at the negedge, check combinational outputs, clock it, check Flags.
    task automatic cyc(input logic rst, input logic [3:0] cond, input logic [3:0] alu,
                       input logic [1:0] fw, input logic pcs, input logic regw,
                       input logic memw, input logic nw, input logic stl);
        logic cx, go;
        reset = rst; bus.Cond = cond; bus.ALUFlags = alu; bus.FlagW = fw;
        bus.PCS = pcs; bus.RegW = regw; bus.MemW = memw; bus.NoWrite = nw; bus.Stall = stl;
        #1;
        cx = refCond(cond, mFlags);
        go = cx && !stl && !rst;
        chk("CondEx",   {3'b0, bus.CondEx},   {3'b0, cx});
        chk("PCSrc",    {3'b0, bus.PCSrc},    {3'b0, pcs && go});
        chk("RegWrite", {3'b0, bus.RegWrite}, {3'b0, regw && go && !nw});
        chk("MemWrite", {3'b0, bus.MemWrite}, {3'b0, memw && go});
        @(posedge clk);
        if (rst) mFlags = FR;
        else if (!stl && cx) begin
            if (fw[1]) mFlags[3:2] = alu[3:2];
            if (fw[0]) mFlags[1:0] = alu[1:0];
        end
        @(negedge clk);
        chk("Flags", bus.Flags, mFlags);
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b1; bus.Cond = 4'hE; bus.ALUFlags = '0; bus.FlagW = '0;
        bus.PCS = 1'b1; bus.RegW = 1'b1; bus.MemW = 1'b1; bus.NoWrite = 1'b0; bus.Stall = 1'b0;
        @(negedge clk);
        #1;
        chk("rstPCSrc",    {3'b0, bus.PCSrc},    4'd0);
        chk("rstRegWrite", {3'b0, bus.RegWrite}, 4'd0);
        chk("rstMemWrite", {3'b0, bus.MemWrite}, 4'd0);
        @(posedge clk);
        @(negedge clk);
        mFlags = FR;

        // T1 reset state
        chk("T1Flags", bus.Flags, 4'b0000);
        cyc(1, 4'b0000, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        cyc(1, 4'b0001, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        reset = 1'b0; bus.Cond = 4'b0000; #1;
        chk("T1EQ", {3'b0, bus.CondEx}, 4'd0);
        bus.Cond = 4'b0001; #1;
        chk("T1NE", {3'b0, bus.CondEx}, 4'd1);

        // T2 split flag write
        cyc(0, 4'hE, 4'b1111, 2'b10, 0, 0, 0, 0, 0);
        chk("T2hi", bus.Flags, 4'b1100);
        cyc(0, 4'hE, 4'b0011, 2'b11, 0, 0, 0, 0, 0);
        chk("T2all", bus.Flags, 4'b0011);

        // T3 annulled instruction
        cyc(0, 4'hE, 4'b0000, 2'b11, 0, 0, 0, 0, 0);
        cyc(0, 4'b0000, 4'b0100, 2'b11, 1, 1, 1, 0, 0);
        chk("T3Flags", bus.Flags, 4'b0000);

        // T4 condition sweep
        for (int f = 0; f < 16; f++) begin
            cyc(0, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0, 0);
            for (int c = 0; c < 16; c++) begin
                bus.Cond = 4'(c); #1;
                chk("T4CondEx", {3'b0, bus.CondEx}, {3'b0, refCond(4'(c), 4'(f))});
            end
        end

        // T5 stall
        cyc(0, 4'hE, 4'b0000, 2'b11, 0, 0, 0, 0, 0);
        cyc(0, 4'hE, 4'b1010, 2'b11, 0, 1, 0, 0, 1);
        cyc(0, 4'hE, 4'b1010, 2'b11, 0, 1, 0, 0, 1);
        chk("T5hold", bus.Flags, 4'b0000);
        cyc(0, 4'hE, 4'b1010, 2'b11, 0, 1, 0, 0, 0);
        chk("T5rel", bus.Flags, 4'b1010);

        // T6 CMP then BEQ, then reset mid-sequence
        cyc(0, 4'hE, 4'b0100, 2'b11, 0, 1, 0, 1, 0);
        bus.Cond = 4'b0000; bus.PCS = 1'b1; bus.FlagW = 2'b00; bus.NoWrite = 1'b0; bus.RegW = 1'b0; #1;
        chk("T6PCSrc", {3'b0, bus.PCSrc}, 4'd1);
        cyc(0, 4'b0000, 4'b1011, 2'b11, 1, 1, 1, 0, 0);
        cyc(1, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0, 1);
        chk("T6rst", bus.Flags, FR);

        // Random
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 15) == 0), 4'($urandom), 4'($urandom), 2'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
